// File: rtl/code_lock.sv
// Four-digit hex combination lock: one attempt per clock, lockout after MAX_TRIES misses.
// Optional macro LOCK_TIMEOUT_EN releases the lockout after LOCKOUT_CYCLES clocks.
module code_lock #(
  parameter logic [15:0] PASSCODE       = 16'h10AF,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 8
) (
  input  logic [3:0]  digit_1,
  input  logic [3:0]  digit_2,
  input  logic [3:0]  digit_3,
  input  logic [3:0]  digit_4,
  input  logic        reset,
  input  logic        clk,
  output logic        out,
  output logic        buzzer,
  output logic [2:0]  count,
  output logic [15:0] cp
);

  if (MAX_TRIES < 1 || MAX_TRIES > 7 || LOCKOUT_CYCLES < 1) begin : g_bad_param
    $error("code_lock: MAX_TRIES must be 1..7 and LOCKOUT_CYCLES >= 1");
  end

  typedef enum logic {OPEN_IDLE, LOCKOUT} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_TRIES);

  state_t      state;
  logic [15:0] attempt;
  logic [15:0] cp_r = PASSCODE;
  logic        last_miss;

  assign attempt   = {digit_1, digit_2, digit_3, digit_4};
  assign cp        = cp_r;
  // widened compare so count+1 cannot wrap at MAX_TRIES=7
  assign last_miss = ({1'b0, count} + 4'd1) == {1'b0, MAX_CNT};

`ifdef LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  logic [TW-1:0] timer;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= OPEN_IDLE;
      out    <= 1'b0;
      buzzer <= 1'b0;
      count  <= 3'd0;
      cp_r   <= PASSCODE;
`ifdef LOCK_TIMEOUT_EN
      timer  <= '0;
`endif
    end else begin
      case (state)
        OPEN_IDLE: begin
          if (attempt == cp_r) begin
            out   <= 1'b1;
            count <= 3'd0;
          end else begin
            out <= 1'b0;
            if (last_miss) begin
              count  <= MAX_CNT;
              buzzer <= 1'b1;
              state  <= LOCKOUT;
`ifdef LOCK_TIMEOUT_EN
              timer  <= TW'(LOCKOUT_CYCLES);
`endif
            end else begin
              count <= count + 3'd1;
            end
          end
        end
        LOCKOUT: begin
          out    <= 1'b0;
          buzzer <= 1'b1;
          count  <= MAX_CNT;
`ifdef LOCK_TIMEOUT_EN
          // exit edge only releases; the next edge evaluates an attempt
          if (timer == TW'(1)) begin
            state  <= OPEN_IDLE;
            buzzer <= 1'b0;
            count  <= 3'd0;
            timer  <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
`endif
        end
        default: state <= OPEN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock.sv
// Directed plan steps followed by random attempts, checked against a behavioural lock model.
module tb_code_lock;
  localparam logic [15:0] PASS = 16'h10AF;
  localparam int          MAXT = 3;
  localparam int          LCYC = 8;

  logic [3:0]  digit_1, digit_2, digit_3, digit_4;
  logic        reset, clk;
  logic        out, buzzer;
  logic [2:0]  count;
  logic [15:0] cp;

  int total = 0;
  int bad   = 0;

  // reference model state: number of consecutive misses, lockout flag, cycles left
  int m_out, m_buz, m_misses, m_locked, m_left;

  code_lock #(.PASSCODE(PASS), .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LCYC)) dut (
    .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3), .digit_4(digit_4),
    .reset(reset), .clk(clk), .out(out), .buzzer(buzzer), .count(count), .cp(cp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] code, input logic rst);
    if (rst) begin
      m_out = 0; m_buz = 0; m_misses = 0; m_locked = 0; m_left = 0;
    end else if (m_locked != 0) begin
`ifdef LOCK_TIMEOUT_EN
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_locked = 0; m_buz = 0; m_misses = 0;
      end
`endif
    end else if (code == PASS) begin
      m_out = 1; m_misses = 0;
    end else begin
      m_out = 0;
      m_misses = m_misses + 1;
      if (m_misses >= MAXT) begin
        m_locked = 1; m_buz = 1; m_left = LCYC;
      end
    end
  endtask

  task automatic step(input logic [15:0] code, input logic rst, input string tag);
    @(negedge clk);
    {digit_1, digit_2, digit_3, digit_4} = code;
    reset = rst;
    @(posedge clk);
    model(code, rst);
    #1;
    chk({tag, ".out"},    {15'd0, out},    16'(m_out));
    chk({tag, ".buzzer"}, {15'd0, buzzer}, 16'(m_buz));
    chk({tag, ".count"},  {13'd0, count},  16'(m_misses));
    chk({tag, ".cp"},     cp,              PASS);
  endtask

  initial begin
    logic [15:0] code;
    reset = 1'b0;
    {digit_1, digit_2, digit_3, digit_4} = 16'h0000;
    m_out = 0; m_buz = 0; m_misses = 0; m_locked = 0; m_left = 0;
    #1;
    chk("powerup.cp", cp, PASS);

    // reset then a wrong code
    step(16'hABCD, 1'b1, "rst");
    chk("rst.count_lit", {13'd0, count}, 16'd0);
    step(16'hABCD, 1'b0, "miss1");
    chk("miss1.count_lit", {13'd0, count}, 16'd1);

    // correct code, held twice
    step(16'h0000, 1'b1, "rst2");
    step(PASS, 1'b0, "open1");
    chk("open1.out_lit", {15'd0, out}, 16'd1);
    step(PASS, 1'b0, "open2");

    // two misses then correct clears count
    step(16'h0000, 1'b1, "rst3");
    step(16'h10A1, 1'b0, "m1");
    step(16'h10A1, 1'b0, "m2");
    chk("m2.count_lit", {13'd0, count}, 16'd2);
    step(PASS, 1'b0, "m2open");
    chk("m2open.count_lit", {13'd0, count}, 16'd0);

    // three misses lock out; correct code ignored
    step(16'h0000, 1'b1, "rst4");
    step(16'h10A1, 1'b0, "l1");
    step(16'h1CAF, 1'b0, "l2");
    step(16'hABCD, 1'b0, "l3");
    chk("l3.buzzer_lit", {15'd0, buzzer}, 16'd1);
    step(PASS, 1'b0, "locked_pass");
    chk("locked_pass.out_lit", {15'd0, out}, 16'd0);

    // reset during lockout, then unlock
    step(PASS, 1'b1, "rst_lock");
    step(PASS, 1'b0, "after_rst");

`ifdef LOCK_TIMEOUT_EN
    step(16'h0001, 1'b0, "t1");
    step(16'h0002, 1'b0, "t2");
    step(16'h0003, 1'b0, "t3");
    for (int i = 0; i < LCYC; i++) step(16'h9999, 1'b0, "hold");
    chk("timeout.buzzer_lit", {15'd0, buzzer}, 16'd0);
    step(PASS, 1'b0, "post_timeout");
`endif

    // random attempts, biased toward the passcode and near-misses
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    code = PASS;
        2:       code = PASS ^ (16'h1 << $urandom_range(0, 15));
        default: code = 16'($urandom);
      endcase
      step(code, ($urandom_range(0, 29) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/code_lock.md
Name: code_lock

Overview:
- Four-digit (hex nibble) combination lock.
- Each clock cycle, the applied 4-digit code is compared against a stored passcode.
- A match asserts `out` (unlock). A mismatch increments an attempt counter.
- Reaching the attempt limit asserts `buzzer` and locks out further attempts until reset.
- Sits between a keypad/digit-entry front end and an actuator/alarm driver.

Parameters:
- PASSCODE, 16'h10AF, stored code; digit_1 = bits[15:12] … digit_4 = bits[3:0].
- MAX_TRIES, 3, consecutive wrong attempts that trigger lockout; legal range 1..7.
- LOCKOUT_CYCLES, 8, lockout duration in clocks; used only with LOCK_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- digit_1  input  4  most significant digit of the attempt.
- digit_2  input  4  second digit.
- digit_3  input  4  third digit.
- digit_4  input  4  least significant digit.
- out  output  1  unlock indication (registered).
- buzzer  output  1  lockout/alarm indication (registered).
- count  output  3  current consecutive wrong-attempt count (registered).
- cp  output  16  stored passcode register, {d1,d2,d3,d4} order.
- Positional port order (must be kept for existing instantiations): digit_1, digit_2, digit_3, digit_4, reset, clk, out, buzzer, count, cp.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset (sampled high at a clock edge) has priority over everything, including mid-lockout:
  - out=0, buzzer=0, count=0, cp=PASSCODE.
  - cp also has an initial (power-up) value of PASSCODE.
- attempt = {digit_1,digit_2,digit_3,digit_4}. Every clock edge with reset=0 counts as one attempt. There is no edge detection: holding a code for N cycles equals N attempts.
- States: OPEN_IDLE (buzzer=0) and LOCKOUT (buzzer=1).
- In OPEN_IDLE, on attempt == cp:
  - out<=1, count<=0.
- In OPEN_IDLE, on attempt != cp:
  - out<=0.
  - If count+1 == MAX_TRIES: count<=MAX_TRIES, buzzer<=1, go to LOCKOUT.
  - Otherwise: count<=count+1.
- In LOCKOUT:
  - Inputs are ignored, including a correct code.
  - out held 0, count held at MAX_TRIES, buzzer held 1.
  - Leaves only via reset, or via the timeout when LOCK_TIMEOUT_EN is defined.
- Latency: outputs reflect the attempt sampled at the previous edge (1-cycle latency). out stays 1 for as long as a matching code is held.
- A correct code with count = MAX_TRIES-1 unlocks and clears count; lockout requires MAX_TRIES consecutive misses.
- count never exceeds MAX_TRIES and never wraps.
- Digits are full hex nibbles 0..F; no validity check.
- cp is constant (PASSCODE) after reset; there is no runtime programming path.

Optional Feature:
- Macro: LOCK_TIMEOUT_EN.
- When defined:
  - Adds an internal down-counter loaded with LOCKOUT_CYCLES on entry to LOCKOUT.
  - When it expires, the block returns to OPEN_IDLE: buzzer<=0, count<=0, out=0.
  - The exit edge does not evaluate an attempt; the first attempt is evaluated on the following edge.
  - Reset still clears immediately.
- When undefined: LOCKOUT persists until reset, and no timer logic is present.

Test Plan:
- Reset high for one edge, then attempt 16'hABCD → out=0, buzzer=0, count=0 after reset; count=1 one cycle after the ABCD attempt. cp reads 16'h10AF throughout.
- After reset, apply 10AF → out=1, count=0 one cycle later. Hold 10AF a second cycle → out stays 1.
- From reset: 10A1, 10A1, then 10AF → count 1 then 2; on 10AF, out=1 and count returns to 0.
- From reset: 10A1, 1CAF, ABCD → count 1, 2, 3; buzzer=1 after the third miss. Then 10AF → out stays 0, count stays 3, buzzer stays 1.
- While in lockout, assert reset for one edge → out=0, buzzer=0, count=0. Then 10AF → out=1.
- With LOCK_TIMEOUT_EN (LOCKOUT_CYCLES=8): force lockout, hold 9999 → buzzer=1 for 8 cycles, then buzzer=0 and count=0. Next 10AF → out=1.
